// File: rtl/macc_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | macc_filter_pkg : shared types and default sizes for the MACC controller    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package macc_filter_pkg;

  localparam int c_tapsDef    = 16;
  localparam int c_dwDef      = 18;
  localparam int c_awDef      = 4;
  localparam int c_spacingDef = 16;
  localparam int c_outW       = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } ctrlState_t;

endpackage
`default_nettype wire

// File: rtl/macc_filter_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | macc_filter_ctrl_if : upstream sample valid/ready stream                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface macc_filter_ctrl_if #(
  parameter int DW = 18
) ();

  logic [DW-1:0] sData;
  logic          sValid;
  logic          sReady;

  modport master (output sData, output sValid, input  sReady);
  modport slave  (input  sData, input  sValid, output sReady);

endinterface
`default_nettype wire

// File: rtl/macc_coef_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | macc_coef_loader : steps ROM addresses and aligns writes to ROM latency     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module macc_coef_loader #(
  parameter int TAPS = 16,
  parameter int DW   = 18,
  parameter int AW   = 4
) (
  input  logic          Clk_i,
  input  logic          Rst_i,
  input  logic          Start_i,
  output logic          Done_o,
  output logic [AW-1:0] RdAddr_o,
  input  logic [DW-1:0] RdData_i,
  output logic [AW-1:0] WrAddr_o,
  output logic [DW-1:0] WrData_o,
  output logic          Wr_o
);

  logic          r_rdActive;
  logic [AW-1:0] r_rdAddr;
  logic          r_wr;
  logic [AW-1:0] r_wrAddr;

  // Write stage trails the read stage by one cycle to match the ROM latency
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_rdActive <= 1'b0;
      r_rdAddr   <= '0;
      r_wr       <= 1'b0;
      r_wrAddr   <= '0;
    end else begin
      r_wr     <= r_rdActive;
      r_wrAddr <= r_rdAddr;
      if (Start_i) begin
        r_rdActive <= 1'b1;
        r_rdAddr   <= '0;
      end else if (r_rdActive) begin
        if (r_rdAddr == AW'(TAPS - 1)) begin
          r_rdActive <= 1'b0;
          r_rdAddr   <= '0;
        end else begin
          r_rdAddr <= r_rdAddr + 1'b1;
        end
      end
    end
  end

  assign RdAddr_o = r_rdAddr;
  assign WrAddr_o = r_wrAddr;
  assign Wr_o     = r_wr;
  assign WrData_o = r_wr ? RdData_i : '0;
  assign Done_o   = r_wr && (r_wrAddr == AW'(TAPS - 1));

endmodule
`default_nettype wire

// File: rtl/macc_filter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | macc_filter_ctrl : paces samples into the MACC filter, reloads coefficients |
// | Optional statistics: MACC_CTRL_STATS_EN.  Revision: 1.0                     |
// +----------------------------------------------------------------------------+
module macc_filter_ctrl
  import macc_filter_pkg::*;
#(
  parameter int TAPS    = c_tapsDef,
  parameter int DW      = c_dwDef,
  parameter int AW      = c_awDef,
  parameter int SPACING = c_spacingDef
) (
  input  logic                    Clk_i,
  input  logic                    Rst_i,
  macc_filter_ctrl_if.slave       sIf,
  output logic [DW-1:0]           FiltData_o,
  output logic                    FiltNd_o,
  input  logic                    FiltValid_i,
  input  logic                    LoadReq_i,
  output logic [AW-1:0]           CoefRdAddr_o,
  input  logic [DW-1:0]           CoefRdData_i,
  output logic [AW-1:0]           CoeffAddr_o,
  output logic [DW-1:0]           CoeffData_o,
  output logic                    CoeffWr_o,
  output logic                    LoadBusy_o,
  output logic                    LoadDone_o
`ifdef MACC_CTRL_STATS_EN
  ,
  output logic [15:0]             StatIssued_o,
  output logic [15:0]             StatStall_o
`endif
);

  localparam int c_gapW = $clog2(SPACING + 1);

  ctrlState_t        r_state;
  ctrlState_t        w_nextState;
  logic              r_loadPend;
  logic [c_gapW-1:0] r_gap;
  logic [c_outW-1:0] r_outstanding;
  logic [DW-1:0]     r_filtData;
  logic              r_filtNd;
  logic              r_loadDone;
  logic              w_sReady;
  logic              w_xfer;
  logic              w_loadStart;
  logic              w_loadDone;

  assign w_sReady   = (r_state == ST_RUN) && (r_gap == '0) && !r_loadPend;
  assign w_xfer     = sIf.sValid && w_sReady;
  assign sIf.sReady = w_sReady;

  always_comb begin
    w_nextState = r_state;
    w_loadStart = 1'b0;
    case (r_state)
      ST_RUN:   if (r_loadPend && !w_xfer) w_nextState = ST_DRAIN;
      ST_DRAIN: begin
        if ((r_outstanding == '0) && (r_gap == '0)) begin
          w_nextState = ST_LOAD;
          w_loadStart = 1'b1;
        end
      end
      ST_LOAD:  if (w_loadDone) w_nextState = ST_RUN;
      default:  w_nextState = ST_RUN;
    endcase
  end

  // Reset leaves loadPend set so the first thing after reset is a full reload
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_state       <= ST_RUN;
      r_loadPend    <= 1'b1;
      r_gap         <= '0;
      r_outstanding <= '0;
      r_filtData    <= '0;
      r_filtNd      <= 1'b0;
      r_loadDone    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (LoadReq_i) r_loadPend <= 1'b1;
      else if (w_loadStart) r_loadPend <= 1'b0;
      if (w_xfer) begin
        r_gap      <= c_gapW'(SPACING - 1);
        r_filtData <= sIf.sData;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
      r_filtNd   <= w_xfer;
      r_loadDone <= (r_state == ST_LOAD) && w_loadDone;
      if (r_filtNd && !FiltValid_i && (r_outstanding != '1))
        r_outstanding <= r_outstanding + 1'b1;
      else if (FiltValid_i && !r_filtNd && (r_outstanding != '0))
        r_outstanding <= r_outstanding - 1'b1;
    end
  end

  macc_coef_loader #(
    .TAPS (TAPS),
    .DW   (DW),
    .AW   (AW)
  ) u_loader (
    .Clk_i    (Clk_i),
    .Rst_i    (Rst_i),
    .Start_i  (w_loadStart),
    .Done_o   (w_loadDone),
    .RdAddr_o (CoefRdAddr_o),
    .RdData_i (CoefRdData_i),
    .WrAddr_o (CoeffAddr_o),
    .WrData_o (CoeffData_o),
    .Wr_o     (CoeffWr_o)
  );

  assign FiltData_o = r_filtData;
  assign FiltNd_o   = r_filtNd;
  assign LoadDone_o = r_loadDone;
  assign LoadBusy_o = r_loadPend || (r_state != ST_RUN);

`ifdef MACC_CTRL_STATS_EN
  logic [15:0] r_statIssued;
  logic [15:0] r_statStall;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_statIssued <= '0;
      r_statStall  <= '0;
    end else begin
      if (r_filtNd) r_statIssued <= r_statIssued + 1'b1;
      if (sIf.sValid && !w_sReady && (r_statStall != 16'hFFFF))
        r_statStall <= r_statStall + 1'b1;
    end
  end

  assign StatIssued_o = r_statIssued;
  assign StatStall_o  = r_statStall;
`endif

endmodule
`default_nettype wire
